axis_sme_stream_adapter: RTL and testbench
==========================================

Name: axis_sme_stream_adapter

Overview:
Converts an AXI-Stream packet stream into the sop/eop/empty, byte-reversed format the string-matcher pipeline consumes. It fixes SOP detection for back-to-back packets and generalises the data width. It also keeps the last TAIL_BYTES bytes of each packet in a per-flow tail store, so later packets on the same flow can match patterns that span packet boundaries. It sits between the packet-distribution AXIS fabric and string_matcher.

Parameters:
BYTE_COUNT, 16, bytes per beat (power of two, ≥8)
TAIL_BYTES, 7, bytes retained per packet (1..BYTE_COUNT-1)
NUM_CH, 4, number of flow channels / tail slots (power of two, ≥2)
PAD_BYTE, 8'hFF, fill value for invalid bytes and unfilled tail bytes

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
s_axis_tdata  input  BYTE_COUNT*8  stream data, byte 0 (bits 7:0) is first on wire
s_axis_tkeep  input  BYTE_COUNT  byte valid
s_axis_tvalid  input  1  beat valid
s_axis_tlast  input  1  last beat of packet
s_axis_tdest  input  log2(NUM_CH)  flow channel, sampled on first beat
s_axis_tready  output  1  beat accepted when tvalid&tready
m_data  output  BYTE_COUNT*8  byte-reversed data, first stream byte in MSB byte
m_empty  output  log2(BYTE_COUNT)  invalid trailing bytes (valid only with m_eop)
m_sop  output  1  first beat of packet
m_eop  output  1  last beat of packet
m_ch  output  log2(NUM_CH)  packet channel
m_valid  output  1  output beat valid
m_ready  input  1  downstream ready
tail_valid  output  1  one-cycle pulse: tail of just-finished packet
tail_ch  output  log2(NUM_CH)  channel of tail_data
tail_data  output  TAIL_BYTES*8  byte 0 = oldest retained byte, byte TAIL_BYTES-1 = final packet byte
tail_rd_ch  input  log2(NUM_CH)  tail store read address
tail_rd_data  output  TAIL_BYTES*8  combinational read of tail store slot
err_cnt  output  16  saturating protocol-violation count

Behaviour:
- Reset (any cycle, including mid-packet):
  - m_valid=0, s_axis_tready=0 in the reset cycle, 1 afterwards.
  - Skid buffer emptied; in_pkt=0.
  - Running tail and every tail slot set to all PAD_BYTE.
  - tail_valid=0, tail_ch=0, tail_data=all PAD_BYTE, err_cnt=0.
  - Partial packet is discarded silently.
- Datapath:
  - Registered output stage plus a 1-entry skid buffer; latency from acceptance to m_valid is 1 cycle.
  - Sustains 1 beat/cycle while m_ready=1.
  - s_axis_tready = !skid_full (registered).
  - m_* hold stable while m_valid & !m_ready.
- Reformatting:
  - m_data byte i = s_axis_tdata byte BYTE_COUNT-1-i; bytes with tkeep=0 are forced to PAD_BYTE.
  - m_empty = number of zero tkeep bits. A zero-keep beat gives empty=0 and an all-PAD data word.
- SOP tracking:
  - in_pkt is set on every accepted beat with !tlast and cleared on an accepted tlast beat.
  - m_sop = !in_pkt at acceptance, so a single-beat packet has sop=eop=1.
  - Back-to-back packets with no idle cycle get correct sop.
- Channel: tdest is latched at the sop beat; m_ch and the tail slot use the latched value for every beat of the packet.
- Protocol errors: err_cnt +1 (saturates at 16'hFFFF) on any accepted beat where:
  - tkeep is non-contiguous from LSB, or
  - tkeep is not all-ones on a non-last beat, or
  - tkeep is zero.
  The beat is still forwarded.
- Running tail:
  - n = popcount(tkeep) stream bytes (low-order, in stream order) are appended to cur_tail; the oldest bytes shift out.
  - At sop, cur_tail starts from all PAD_BYTE.
  - Packets shorter than TAIL_BYTES leave PAD_BYTE in the oldest positions.
  - Updates at input acceptance, independent of m_ready.
- Tail commit:
  - On an accepted tlast beat, the final cur_tail is written to slot[ch].
  - Next cycle: tail_valid=1, tail_ch=ch, tail_data=that value.
  - tail_rd_data reflects the write from the cycle after commit.
  - The slot is written even on error beats.

Test Plan:
- 19-byte packet bytes 0x00..0x12 (beat1 keep FFFF, beat2 keep 0007), ch=2, m_ready=1 → beat1 m_data MSB byte=0x00, sop=1. Beat2 eop=1, empty=13, top 3 bytes 10 11 12, rest FF. tail_data bytes 0..6 = 0C..12, tail_ch=2.
- 3-byte packet AA BB CC, keep=0007, ch=1 → sop=eop=1, empty=13. tail_data bytes 0..6 = FF FF FF FF AA BB CC. tail_rd_ch=1 returns the same next cycle.
- Three 1-beat packets back-to-back, tvalid held high → m_sop=1 and m_eop=1 on all three outputs. Three tail_valid pulses.
- 4-beat packet; m_ready low for 5 cycles mid-packet → no loss or duplication. Output order is identical. s_axis_tready drops within 2 cycles of the stall and recovers.
- tkeep=0x00F0 on a last beat, then tkeep=0x00FF on a non-last beat → err_cnt=2, both beats forwarded.
- rst asserted mid-packet → m_valid=0 the next cycle, all slots PAD. Next beat is treated as sop=1.

Source files
------------

// File: rtl/axis_sme_stream_adapter.sv
// AXI-Stream to string-matcher adapter: byte reversal, sop/eop/empty framing,
// 1-entry skid buffer and a per-flow store of each packet's trailing bytes.
module axis_sme_stream_adapter #(
    parameter int         BYTE_COUNT = 16,
    parameter int         TAIL_BYTES = 7,
    parameter int         NUM_CH     = 4,
    parameter logic [7:0] PAD_BYTE   = 8'hFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [BYTE_COUNT*8-1:0]       s_axis_tdata,
    input  logic [BYTE_COUNT-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    input  logic [$clog2(NUM_CH)-1:0]     s_axis_tdest,
    output logic                          s_axis_tready,
    output logic [BYTE_COUNT*8-1:0]       m_data,
    output logic [$clog2(BYTE_COUNT)-1:0] m_empty,
    output logic                          m_sop,
    output logic                          m_eop,
    output logic [$clog2(NUM_CH)-1:0]     m_ch,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          tail_valid,
    output logic [$clog2(NUM_CH)-1:0]     tail_ch,
    output logic [TAIL_BYTES*8-1:0]       tail_data,
    input  logic [$clog2(NUM_CH)-1:0]     tail_rd_ch,
    output logic [TAIL_BYTES*8-1:0]       tail_rd_data,
    output logic [15:0]                   err_cnt
);

    localparam int EW = $clog2(BYTE_COUNT);
    localparam int CW = $clog2(NUM_CH);
    localparam int NW = EW + 1;

    // Byte 0 of a tail word is the oldest retained byte.
    typedef logic [TAIL_BYTES-1:0][7:0] tail_t;

    typedef struct packed {
        logic [BYTE_COUNT*8-1:0] data;
        logic [EW-1:0]           empty;
        logic                    sop;
        logic                    eop;
        logic [CW-1:0]           ch;
    } beat_t;

    localparam tail_t PAD_TAIL = {TAIL_BYTES{PAD_BYTE}};

    logic            r_ready;
    beat_t           r_out;
    logic            r_out_valid;
    beat_t           r_skid;
    logic            r_skid_full;
    logic            r_in_pkt;
    logic [CW-1:0]   r_cur_ch;
    tail_t           r_cur_tail;
    tail_t           r_slot [NUM_CH];
    logic            r_tail_valid;
    logic [CW-1:0]   r_tail_ch;
    tail_t           r_tail_data;
    logic [15:0]     r_err_cnt;

    logic            w_accept;
    logic            w_out_free;
    logic            w_skid_full_nxt;
    logic            w_sop;
    logic [CW-1:0]   w_ch;
    beat_t           w_beat;
    logic [NW-1:0]   w_nkeep;
    logic [EW-1:0]   w_empty;
    logic [BYTE_COUNT-1:0] w_keep_inc;
    logic            w_err;
    tail_t           w_tail;

    assign w_accept   = s_axis_tvalid && r_ready;
    assign w_out_free = !r_out_valid || m_ready;
    assign w_sop      = !r_in_pkt;
    assign w_ch       = r_in_pkt ? r_cur_ch : s_axis_tdest;

    // The skid entry fills only when the output stage is stalled; tready is
    // registered from the next-state fullness so it never depends on m_ready.
    assign w_skid_full_nxt = w_out_free ? 1'b0 : (r_skid_full || w_accept);

    // NOTE: every variable written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred; blocking '=' is correct in comb logic.
    always_comb begin
        w_beat  = '0;
        w_nkeep = '0;
        w_empty = '0;
        for (int i = 0; i < BYTE_COUNT; i++) begin
            if (s_axis_tkeep[i]) begin
                w_beat.data[(BYTE_COUNT-1-i)*8 +: 8] = s_axis_tdata[i*8 +: 8];
                w_nkeep = w_nkeep + NW'(1);
            end else begin
                w_beat.data[(BYTE_COUNT-1-i)*8 +: 8] = PAD_BYTE;
                w_empty = w_empty + EW'(1);
            end
        end
        // An all-zero keep wraps the empty count to 0.
        w_beat.empty = w_empty;
        w_beat.sop   = w_sop;
        w_beat.eop   = s_axis_tlast;
        w_beat.ch    = w_ch;
    end

    // Append the low-order popcount(tkeep) stream bytes, oldest shifting out.
    always_comb begin
        w_tail = w_sop ? PAD_TAIL : r_cur_tail;
        for (int i = 0; i < BYTE_COUNT; i++) begin
            if (i < int'(w_nkeep)) begin
                for (int j = 0; j < TAIL_BYTES - 1; j++) begin
                    w_tail[j] = w_tail[j+1];
                end
                w_tail[TAIL_BYTES-1] = s_axis_tdata[i*8 +: 8];
            end
        end
    end

    assign w_keep_inc = s_axis_tkeep + {{(BYTE_COUNT-1){1'b0}}, 1'b1};
    assign w_err = ((s_axis_tkeep & w_keep_inc) != '0)
                || (!s_axis_tlast && (s_axis_tkeep != '1))
                || (s_axis_tkeep == '0);

    // NOTE: sequential state uses non-blocking '<=' only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready      <= 1'b0;
            r_out        <= '0;
            r_out_valid  <= 1'b0;
            r_skid       <= '0;
            r_skid_full  <= 1'b0;
            r_in_pkt     <= 1'b0;
            r_cur_ch     <= '0;
            r_cur_tail   <= PAD_TAIL;
            // NOTE: the slot array is a handful of flops that must read as PAD
            // after reset, so it is reset explicitly rather than left as RAM.
            for (int c = 0; c < NUM_CH; c++) begin
                r_slot[c] <= PAD_TAIL;
            end
            r_tail_valid <= 1'b0;
            r_tail_ch    <= '0;
            r_tail_data  <= PAD_TAIL;
            r_err_cnt    <= '0;
        end else begin
            if (w_out_free) begin
                if (r_skid_full) begin
                    r_out       <= r_skid;
                    r_out_valid <= 1'b1;
                    r_skid_full <= 1'b0;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept) begin
                        r_out <= w_beat;
                    end
                end
            end else if (w_accept) begin
                r_skid      <= w_beat;
                r_skid_full <= 1'b1;
            end
            r_ready <= !w_skid_full_nxt;

            r_tail_valid <= 1'b0;
            if (w_accept) begin
                r_in_pkt   <= !s_axis_tlast;
                r_cur_tail <= w_tail;
                if (w_sop) begin
                    r_cur_ch <= s_axis_tdest;
                end
                if (s_axis_tlast) begin
                    r_slot[w_ch] <= w_tail;
                    r_tail_valid <= 1'b1;
                    r_tail_ch    <= w_ch;
                    r_tail_data  <= w_tail;
                end
                if (w_err && (r_err_cnt != 16'hFFFF)) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end

    assign s_axis_tready = r_ready;
    assign m_data        = r_out.data;
    assign m_empty       = r_out.empty;
    assign m_sop         = r_out.sop;
    assign m_eop         = r_out.eop;
    assign m_ch          = r_out.ch;
    assign m_valid       = r_out_valid;
    assign tail_valid    = r_tail_valid;
    assign tail_ch       = r_tail_ch;
    assign tail_data     = r_tail_data;
    assign tail_rd_data  = r_slot[tail_rd_ch];
    assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_axis_sme_stream_adapter.sv
// Directed-vector bench for axis_sme_stream_adapter: expected beats and tail
// commits are queued at stimulus time and popped by independent monitors.
module tb_axis_sme_stream_adapter;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  s_axis_tdata;
    logic [15:0]   s_axis_tkeep;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic [1:0]    s_axis_tdest;
    logic          s_axis_tready;
    logic [127:0]  m_data;
    logic [3:0]    m_empty;
    logic          m_sop;
    logic          m_eop;
    logic [1:0]    m_ch;
    logic          m_valid;
    logic          m_ready;
    logic          tail_valid;
    logic [1:0]    tail_ch;
    logic [55:0]   tail_data;
    logic [1:0]    tail_rd_ch;
    logic [55:0]   tail_rd_data;
    logic [15:0]   err_cnt;

    axis_sme_stream_adapter #(
        .BYTE_COUNT (16),
        .TAIL_BYTES (7),
        .NUM_CH     (4),
        .PAD_BYTE   (8'hFF)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdest  (s_axis_tdest),
        .s_axis_tready (s_axis_tready),
        .m_data        (m_data),
        .m_empty       (m_empty),
        .m_sop         (m_sop),
        .m_eop         (m_eop),
        .m_ch          (m_ch),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .tail_valid    (tail_valid),
        .tail_ch       (tail_ch),
        .tail_data     (tail_data),
        .tail_rd_ch    (tail_rd_ch),
        .tail_rd_data  (tail_rd_data),
        .err_cnt       (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   empty;
        logic         sop;
        logic         eop;
        logic [1:0]   ch;
    } beat_t;

    typedef struct {
        logic [1:0]  ch;
        logic [55:0] data;
    } tail_t;

    localparam logic [55:0] PAD56 = 56'hFFFFFFFFFFFFFF;

    beat_t exp_q [$];
    tail_t tail_q [$];
    int    n_vec = 0;
    int    n_err = 0;
    bit    saw_low;
    bit    saw_high;

    function automatic logic [127:0] fmt_data(input logic [127:0] d, input logic [15:0] k);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[(15-i)*8 +: 8] = k[i] ? d[i*8 +: 8] : 8'hFF;
        end
        return r;
    endfunction

    function automatic logic [3:0] zero_cnt(input logic [15:0] k);
        int z = 0;
        for (int i = 0; i < 16; i++) begin
            if (!k[i]) z++;
        end
        return 4'(z);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_tail(input logic [1:0] ch, input logic [55:0] data);
        tail_t t;
        t.ch   = ch;
        t.data = data;
        tail_q.push_back(t);
    endtask

    // Present one beat, wait (bounded) for acceptance, queue its expected output.
    task automatic send(input logic [127:0] d, input logic [15:0] k, input logic last,
                        input logic [1:0] dest, input logic exp_sop, input logic [1:0] exp_ch);
        beat_t b;
        bit    got = 1'b0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = last;
        s_axis_tdest  = dest;
        s_axis_tvalid = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (s_axis_tready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: tready stayed 0, required 1");
        end else begin
            b.data  = fmt_data(d, k);
            b.empty = zero_cnt(k);
            b.sop   = exp_sop;
            b.eop   = last;
            b.ch    = exp_ch;
            exp_q.push_back(b);
        end
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    always @(negedge clk) begin : mon_out
        beat_t e;
        if (!rst && m_valid && m_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_beat: unexpected beat data=%h sop=%b eop=%b", m_data, m_sop, m_eop);
            end else begin
                e = exp_q.pop_front();
                if (m_data !== e.data || m_empty !== e.empty || m_sop !== e.sop ||
                    m_eop !== e.eop || m_ch !== e.ch) begin
                    n_err++;
                    $display("FAIL out_beat: got data=%h empty=%0d sop=%b eop=%b ch=%0d, required data=%h empty=%0d sop=%b eop=%b ch=%0d",
                             m_data, m_empty, m_sop, m_eop, m_ch, e.data, e.empty, e.sop, e.eop, e.ch);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_tail
        tail_t e;
        if (!rst && tail_valid) begin
            n_vec++;
            if (tail_q.size() == 0) begin
                n_err++;
                $display("FAIL tail_pulse: unexpected pulse ch=%0d data=%h", tail_ch, tail_data);
            end else begin
                e = tail_q.pop_front();
                if (tail_ch !== e.ch || tail_data !== e.data) begin
                    n_err++;
                    $display("FAIL tail_pulse: got ch=%0d data=%h, required ch=%0d data=%h",
                             tail_ch, tail_data, e.ch, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] d;

        rst           = 1'b1;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdest  = '0;
        m_ready       = 1'b1;
        tail_rd_ch    = '0;

        // Reset state
        @(posedge clk); #1;
        check("rst_m_valid",    64'(m_valid),       64'd0);
        check("rst_tready",     64'(s_axis_tready), 64'd0);
        check("rst_err_cnt",    64'(err_cnt),       64'd0);
        check("rst_tail_valid", 64'(tail_valid),    64'd0);
        check("rst_tail_ch",    64'(tail_ch),       64'd0);
        check("rst_tail_data",  64'(tail_data),     64'(PAD56));
        for (int c = 0; c < 4; c++) begin
            tail_rd_ch = 2'(c);
            #1;
            check("rst_slot", 64'(tail_rd_data), 64'(PAD56));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_tready", 64'(s_axis_tready), 64'd1);

        // 19-byte packet on channel 2; second beat's tdest must be ignored
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i);
        send(d, 16'hFFFF, 1'b0, 2'd2, 1'b1, 2'd2);
        d = {16{8'hEE}};
        d[23:0] = 24'h121110;
        push_tail(2'd2, 56'h1211100F0E0D0C);
        send(d, 16'h0007, 1'b1, 2'd0, 1'b0, 2'd2);

        // 3-byte packet AA BB CC on channel 1
        d = '0;
        d[23:0] = 24'hCCBBAA;
        push_tail(2'd1, 56'hCCBBAAFFFFFFFF);
        send(d, 16'h0007, 1'b1, 2'd1, 1'b1, 2'd1);
        @(negedge clk); #1;
        tail_rd_ch = 2'd1;
        #1;
        check("slot1_read", 64'(tail_rd_data), 64'(56'hCCBBAAFFFFFFFF));
        tail_rd_ch = 2'd2;
        #1;
        check("slot2_read", 64'(tail_rd_data), 64'(56'h1211100F0E0D0C));
        @(posedge clk); #1;

        // Three single-beat packets back to back
        d = '0; d[7:0] = 8'h01;
        push_tail(2'd0, 56'h01FFFFFFFFFFFF);
        send(d, 16'h0001, 1'b1, 2'd0, 1'b1, 2'd0);
        d = '0; d[15:0] = 16'h0302;
        push_tail(2'd1, 56'h0302FFFFFFFFFF);
        send(d, 16'h0003, 1'b1, 2'd1, 1'b1, 2'd1);
        d = '0; d[23:0] = 24'h060504;
        push_tail(2'd3, 56'h060504FFFFFFFF);
        send(d, 16'h0007, 1'b1, 2'd3, 1'b1, 2'd3);

        // 4-beat packet with a downstream stall in the middle
        saw_low  = 1'b0;
        saw_high = 1'b0;
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(b*16 + i + 8'h20);
                    send(d, 16'hFFFF, 1'b0, 2'd1, (b == 0), 2'd1);
                end
                for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 8'h80);
                push_tail(2'd1, 56'h87868584838281);
                send(d, 16'h00FF, 1'b1, 2'd1, 1'b0, 2'd1);
            end
            begin
                repeat (2) @(posedge clk);
                #1 m_ready = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    if (!s_axis_tready) saw_low = 1'b1;
                end
                repeat (3) @(negedge clk);
                @(posedge clk);
                #1 m_ready = 1'b1;
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    if (s_axis_tready) saw_high = 1'b1;
                end
            end
        join
        check("stall_tready_drop",    64'(saw_low),  64'd1);
        check("stall_tready_recover", 64'(saw_high), 64'd1);

        // Protocol errors: gapped keep on a last beat, partial keep mid-packet
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 8'h20);
        push_tail(2'd0, 56'h23222120FFFFFF);
        send(d, 16'h00F0, 1'b1, 2'd0, 1'b1, 2'd0);
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 8'h30);
        send(d, 16'h00FF, 1'b0, 2'd2, 1'b1, 2'd2);
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 8'h40);
        push_tail(2'd2, 56'h4F4E4D4C4B4A49);
        send(d, 16'hFFFF, 1'b1, 2'd3, 1'b0, 2'd2);
        repeat (2) @(posedge clk); #1;
        check("err_cnt_two", 64'(err_cnt), 64'd2);

        // Zero-keep beat: empty=0, all-PAD data, counted as an error
        d = {16{8'h5A}};
        push_tail(2'd0, PAD56);
        send(d, 16'h0000, 1'b1, 2'd0, 1'b1, 2'd0);
        repeat (2) @(posedge clk); #1;
        check("err_cnt_three", 64'(err_cnt), 64'd3);

        // Reset in the middle of a packet
        for (int i = 0; i < 16; i++) d[i*8 +: 8] = 8'(i + 8'h70);
        send(d, 16'hFFFF, 1'b0, 2'd1, 1'b1, 2'd1);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_m_valid", 64'(m_valid),       64'd0);
        check("midrst_tready",  64'(s_axis_tready), 64'd0);
        check("midrst_err_cnt", 64'(err_cnt),       64'd0);
        check("midrst_tail",    64'(tail_data),     64'(PAD56));
        for (int c = 0; c < 4; c++) begin
            tail_rd_ch = 2'(c);
            #1;
            check("midrst_slot", 64'(tail_rd_data), 64'(PAD56));
        end
        rst = 1'b0;
        @(posedge clk); #1;
        d = '0; d[15:0] = 16'h6655;
        push_tail(2'd3, 56'h6655FFFFFFFFFF);
        send(d, 16'h0003, 1'b1, 2'd3, 1'b1, 2'd3);

        repeat (10) @(posedge clk); #1;
        check("out_queue_drained",  64'(exp_q.size()),  64'd0);
        check("tail_queue_drained", 64'(tail_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
